calc_sequencer: RTL and testbench

- Control FSM for the calculator datapath.
- Accepts an opcode, then two 32-bit operands over a valid/ready handshake. Drives the load enables of the operand-A, operand-B and result registers. Starts the ALU, waits for its completion and presents the result status to the front end.
- Sits between the keypad/host interface and the register+ALU datapath. Carries no data itself; all 32-bit values stay in the datapath.

---
 rtl/calc_pkg.sv | 37 +++
 rtl/calc_timeout_counter.sv | 43 ++++
 rtl/calc_sequencer.sv | 157 +++++++++++++++
 tb/tb_calc_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared opcodes, status codes and state encoding for the calculator sequencer.
package calc_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned ERR_W = 2;

  localparam logic [OP_W-1:0] OP_ADD     = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB     = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL     = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV     = 3'd3;
  localparam logic [OP_W-1:0] OP_AND     = 3'd4;
  localparam logic [OP_W-1:0] OP_OR      = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR     = 3'd6;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

  localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
  localparam logic [ERR_W-1:0] ERR_DIV0    = 2'd1;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_A    = 3'd1,
    ST_GET_B    = 3'd2,
    ST_CHECK    = 3'd3,
    ST_EXEC     = 3'd4,
    ST_WAIT_ALU = 3'd5,
    ST_WRITE    = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  // A division whose divisor register holds zero must not reach the ALU.
  function automatic logic is_div_by_zero(input logic [OP_W-1:0] op, input logic b_zero);
    return (op == OP_DIV) && b_zero;
  endfunction

endpackage

// File: rtl/calc_timeout_counter.sv
// Cycle counter bounding how long the sequencer waits for the ALU.
module calc_timeout_counter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             expired_q;
  logic             expired_d;

  // Next count: clear wins over increment; expiry tracks the next count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expired_d = (cnt_d == CNT_W'(TIMEOUT - 1));
  end

  // Count and registered expiry flag (flag equals cnt_q == TIMEOUT-1).
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      expired_q <= 1'(TIMEOUT == 1);
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/calc_sequencer.sv
// Control FSM for the calculator datapath: opcode/operand handshakes,
// register load enables, ALU start/wait with timeout, and result status.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_code,
  input  logic       opnd_valid,
  output logic       opnd_ready,
  output logic       load_a,
  output logic       load_b,
  input  logic       b_is_zero,
  output logic [2:0] alu_op,
  output logic       alu_start,
  input  logic       alu_done,
  output logic       load_result,
  output logic       busy,
  output logic       result_valid,
  output logic [1:0] result_err,
  input  logic       result_ack
);

  state_e            state_q;
  state_e            state_d;
  logic [OP_W-1:0]   op_q;
  logic [OP_W-1:0]   op_d;
  logic [ERR_W-1:0]  err_q;
  logic [ERR_W-1:0]  err_d;

  logic              cnt_clear;
  logic              cnt_en;
  logic              tmo_expired;

  calc_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (cnt_clear),
    .en_i     (cnt_en),
    .expired_o(tmo_expired)
  );

  // State, latched opcode and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  // Next-state, opcode latch and status decisions.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          op_d = op_code;
          if (op_code == OP_ILLEGAL) begin
            state_d = ST_DONE;
            err_d   = ERR_ILLEGAL;
          end else begin
            state_d = ST_GET_A;
          end
        end
      end
      ST_GET_A: begin
        if (opnd_valid) state_d = ST_GET_B;
      end
      ST_GET_B: begin
        if (opnd_valid) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (is_div_by_zero(op_q, b_is_zero)) begin
          state_d = ST_DONE;
          err_d   = ERR_DIV0;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_WAIT_ALU;
      end
      ST_WAIT_ALU: begin
        // A completion on the final allowed cycle still counts as success.
        if (alu_done) begin
          state_d = ST_WRITE;
        end else if (tmo_expired) begin
          state_d = ST_DONE;
          err_d   = ERR_TIMEOUT;
        end
      end
      ST_WRITE: begin
        state_d = ST_DONE;
        err_d   = ERR_NONE;
      end
      ST_DONE: begin
        if (result_ack) begin
          state_d = ST_IDLE;
          err_d   = ERR_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake readies and one-hot load/start strobes decoded from state.
  always_comb begin
    op_ready     = 1'b0;
    opnd_ready   = 1'b0;
    load_a       = 1'b0;
    load_b       = 1'b0;
    alu_start    = 1'b0;
    load_result  = 1'b0;
    result_valid = 1'b0;
    busy         = (state_q != ST_IDLE);
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    unique case (state_q)
      ST_IDLE:     op_ready = 1'b1;
      ST_GET_A: begin
        opnd_ready = 1'b1;
        load_a     = opnd_valid;
      end
      ST_GET_B: begin
        opnd_ready = 1'b1;
        load_b     = opnd_valid;
      end
      ST_EXEC: begin
        alu_start = 1'b1;
        cnt_clear = 1'b1;
      end
      ST_WAIT_ALU: cnt_en       = 1'b1;
      ST_WRITE:    load_result  = 1'b1;
      ST_DONE:     result_valid = 1'b1;
      default:     ;
    endcase
  end

  assign alu_op     = op_q;
  assign result_err = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: vector table plus scoreboard,
// with a small ALU and B-register model standing in for the datapath.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int unsigned TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code = 3'd0;
  logic        opnd_valid = 1'b0;
  logic        opnd_ready;
  logic        load_a;
  logic        load_b;
  logic        b_is_zero;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic        load_result;
  logic        busy;
  logic        result_valid;
  logic [1:0]  result_err;
  logic        result_ack = 1'b0;

  logic [31:0] opnd_data = '0;
  logic [31:0] b_reg = '0;
  logic        alu_done_m = 1'b0;
  logic        late_done = 1'b0;

  always #5 clk = ~clk;

  calc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .opnd_valid  (opnd_valid),
    .opnd_ready  (opnd_ready),
    .load_a      (load_a),
    .load_b      (load_b),
    .b_is_zero   (b_is_zero),
    .alu_op      (alu_op),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .load_result (load_result),
    .busy        (busy),
    .result_valid(result_valid),
    .result_err  (result_err),
    .result_ack  (result_ack)
  );

  assign alu_done  = alu_done_m | late_done;
  assign b_is_zero = (b_reg == 32'd0);

  // gap: idle cycles before operand B; alu_lat: start-to-done cycles (0 = never);
  // exp_lat counted from the accepting edge, exp_s2v from the alu_start edge (-1 = n/a).
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          gap;
    int          alu_lat;
    int          ack_dly;
    bit          noise;
    logic [1:0]  exp_err;
    int          exp_la;
    int          exp_lb;
    int          exp_st;
    int          exp_lr;
    int          exp_lat;
    int          exp_s2v;
  } vec_t;

  localparam int NVEC = 11;
  vec_t tbl [NVEC];
  vec_t sb [$];
  vec_t cur_v;
  vec_t e_cur;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int start_cyc = 0;
  int n_la = 0, n_lb = 0, n_st = 0, n_lr = 0;
  int rem = 0;
  logic rv_prev = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model plus scoreboard monitor, all evaluated mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      rem        = 0;
      alu_done_m = 1'b0;
      rv_prev    = 1'b0;
    end else begin
      if (load_b) b_reg = opnd_data;
      if (alu_start) begin
        rem        = cur_v.alu_lat;
        alu_done_m = 1'b0;
      end else if (rem > 0) begin
        rem        = rem - 1;
        alu_done_m = (rem == 0);
      end else begin
        alu_done_m = 1'b0;
      end

      if (load_a | load_b | alu_start | load_result)
        check("strobe_excl", $countones({load_a, load_b, alu_start, load_result}), 1);
      if (op_valid && busy) check("ready_while_busy", int'(op_ready), 0);

      if (op_valid && op_ready) begin
        sb.push_back(cur_v);
        n_la = 0; n_lb = 0; n_st = 0; n_lr = 0;
        acc_cyc = cyc + 1;
      end
      n_la += int'(load_a);
      n_lb += int'(load_b);
      n_st += int'(alu_start);
      n_lr += int'(load_result);
      if (alu_start) start_cyc = cyc + 1;

      if (result_valid) begin
        if (!rv_prev) begin
          check("sb_depth", sb.size(), 1);
          if (sb.size() > 0) begin
            e_cur = sb.pop_front();
            check("result_err", int'(result_err), int'(e_cur.exp_err));
            check("n_load_a", n_la, e_cur.exp_la);
            check("n_load_b", n_lb, e_cur.exp_lb);
            check("n_alu_start", n_st, e_cur.exp_st);
            check("n_load_result", n_lr, e_cur.exp_lr);
            if (e_cur.exp_lat >= 0) check("accept_to_valid", cyc - acc_cyc, e_cur.exp_lat);
            if (e_cur.exp_s2v >= 0) check("start_to_valid", cyc - start_cyc, e_cur.exp_s2v);
          end
        end else begin
          check("err_stable", int'(result_err), int'(e_cur.exp_err));
        end
        check("done_quiet", int'({load_a, load_b, alu_start, load_result}), 0);
        if (opnd_valid) check("done_opnd_ready", int'(opnd_ready), 0);
      end else if (rv_prev) begin
        check("err_cleared", int'(result_err), int'(ERR_NONE));
      end
      rv_prev = result_valid;
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b1; op_valid = 1'b0; opnd_valid = 1'b0; result_ack = 1'b0; late_done = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = op_ready;
    end
    if (!ok) check("idle_wait", int'(op_ready), 1);
  endtask

  task automatic send_opnd(input logic [31:0] d);
    bit ok = 1'b0;
    opnd_valid = 1'b1;
    opnd_data  = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = opnd_ready;
    end
    if (!ok) check("opnd_wait", int'(opnd_ready), 1);
    @(posedge clk);
    #1 opnd_valid = 1'b0;
  endtask

  // Offer the opcode, then both operands (with optional gap and busy-time noise).
  task automatic start_op(input vec_t v);
    wait_idle();
    cur_v = v;
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = v.op;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = OP_ADD;
    if (v.op != OP_ILLEGAL) begin
      send_opnd(v.a);
      if (v.gap > 0) begin
        if (v.noise) begin
          op_valid = 1'b1; op_code = OP_ILLEGAL; result_ack = 1'b1;
        end
        repeat (v.gap) begin
          @(posedge clk); #1;
          op_valid = 1'b0; result_ack = 1'b0;
        end
      end
      send_opnd(v.b);
    end
  endtask

  // Wait for status, hold off the ack, then ack with a simultaneous op offer.
  task automatic finish_op(input vec_t v);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = result_valid;
    end
    if (!got) begin
      check("result_valid_wait", int'(result_valid), 1);
      do_reset(2);
    end else begin
      repeat (v.ack_dly) begin
        @(posedge clk); #1;
        if (v.noise) opnd_valid = 1'b1;
      end
      @(posedge clk); #1;
      result_ack = 1'b1; op_valid = 1'b1; op_code = OP_SUB; opnd_valid = 1'b0;
      @(posedge clk); #1;
      result_ack = 1'b0; op_valid = 1'b0;
      @(negedge clk);
      check("ready_after_ack", int'(op_ready), 1);
      check("busy_after_ack", int'(busy), 0);
      check("sb_drained", sb.size(), 0);
    end
  endtask

  initial begin
    vec_t v;
    bit   seen;
    //            op          a      b     gap lat ack noise err          la lb st lr lat s2v
    tbl[0]  = '{OP_ADD,     32'd5, 32'd7,  0,  1,  0, 1'b0, ERR_NONE,    1, 1, 1, 1,  6,  2};
    tbl[1]  = '{OP_SUB,     32'd9, 32'd4,  3,  4, 10, 1'b1, ERR_NONE,    1, 1, 1, 1, 12,  5};
    tbl[2]  = '{OP_DIV,    32'd10, 32'd0,  0,  1,  2, 1'b0, ERR_DIV0,    1, 1, 0, 0,  3, -1};
    tbl[3]  = '{OP_MUL,     32'd3, 32'd3,  0,  0,  1, 1'b0, ERR_TIMEOUT, 1, 1, 1, 0, 68, 64};
    tbl[4]  = '{OP_ILLEGAL, 32'd0, 32'd0,  0,  1,  3, 1'b1, ERR_ILLEGAL, 0, 0, 0, 0,  0, -1};
    tbl[5]  = '{OP_DIV,    32'd10, 32'd2,  0,  2,  0, 1'b0, ERR_NONE,    1, 1, 1, 1,  7,  3};
    tbl[6]  = '{OP_AND,     32'd6, 32'd3,  1,  1,  0, 1'b0, ERR_NONE,    1, 1, 1, 1,  7,  2};
    tbl[7]  = '{OP_XOR,     32'd1, 32'd2,  0, 64,  0, 1'b0, ERR_NONE,    1, 1, 1, 1, 69, 65};
    tbl[8]  = '{OP_OR,      32'd1, 32'd2,  0, 63,  0, 1'b0, ERR_NONE,    1, 1, 1, 1, 68, 64};
    tbl[9]  = '{OP_MUL,     32'd4, 32'd0,  0,  1,  0, 1'b0, ERR_NONE,    1, 1, 1, 1,  6,  2};
    tbl[10] = '{OP_DIV,     32'd8, 32'd0,  2,  1,  4, 1'b1, ERR_DIV0,    1, 1, 0, 0,  5, -1};
    cur_v = tbl[0];

    do_reset(3);
    @(negedge clk);
    check("rst_op_ready", int'(op_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_outputs", int'({opnd_ready, load_a, load_b, alu_start, load_result, result_valid}), 0);
    check("rst_alu_op", int'(alu_op), 0);
    check("rst_err", int'(result_err), 0);

    for (int i = 0; i < NVEC; i++) begin
      start_op(tbl[i]);
      finish_op(tbl[i]);
    end

    // Reset while waiting on a never-finishing ALU, then a stray late done.
    v = '{OP_MUL, 32'd6, 32'd7, 0, 0, 0, 1'b0, ERR_NONE, 0, 0, 0, 0, -1, -1};
    start_op(v);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = alu_start;
    end
    check("mid_reset_start_seen", int'(alu_start), 1);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_op_ready", int'(op_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_outputs", int'({opnd_ready, load_a, load_b, alu_start, load_result, result_valid}), 0);
    check("mid_rst_alu_op", int'(alu_op), 0);
    check("mid_rst_err", int'(result_err), 0);
    @(posedge clk); #1 late_done = 1'b1;
    @(posedge clk); #1 late_done = 1'b0;
    repeat (2) @(negedge clk);
    check("late_done_busy", int'(busy), 0);
    check("late_done_quiet", int'({load_result, result_valid}), 0);

    start_op(tbl[0]);
    finish_op(tbl[0]);
    check("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
